// File: rtl/snd_pkg.sv
// Purpose : shared widths, FSM encoding and byte-swap word format for the sound FIFO pair.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
//   The snd_fft side uses unfmt_l/unfmt_r to undo the writer's fmt_l/fmt_r.
package snd_pkg;

    localparam int SND_W  = 16;
    localparam int FIFO_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } snd_state_t;

    // Left word: byte-swapped sample in the upper half, filler below.
    function automatic logic [FIFO_W-1:0] fmt_l(input logic [SND_W-1:0] s,
                                                input logic [SND_W-1:0] pad);
        return {s[7:0], s[15:8], pad};
    endfunction

    // Right word: filler above, byte-swapped sample in the lower half.
    function automatic logic [FIFO_W-1:0] fmt_r(input logic [SND_W-1:0] s,
                                                input logic [SND_W-1:0] pad);
        return {pad, s[7:0], s[15:8]};
    endfunction

    function automatic logic [SND_W-1:0] unfmt_l(input logic [FIFO_W-1:0] w);
        return {w[23:16], w[31:24]};
    endfunction

    function automatic logic [SND_W-1:0] unfmt_r(input logic [FIFO_W-1:0] w);
        return {w[7:0], w[15:8]};
    endfunction

endpackage

// File: rtl/snd_pair_buf.sv
// Purpose : 2^AW-entry circular buffer of raw {L,R} sample pairs.
// Latency : a pushed entry is visible at pop_dat the cycle after the push edge.
// Backpr. : caller must not push when full nor pop when empty; no internal guarding.
//   Ports: CLK, RST (sync, active-high); push/push_dat in; pop in; pop_dat = head entry;
//   level = entries held, full/empty flags derived from level.
import snd_pkg::*;

module snd_pair_buf #(
    parameter int AW = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              push,
    input  logic [FIFO_W-1:0] push_dat,
    input  logic              pop,
    output logic [FIFO_W-1:0] pop_dat,
    output logic [AW:0]       level,
    output logic              full,
    output logic              empty
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [FIFO_W-1:0] mem [2**AW];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // Pointers are exactly AW bits wide, so they wrap modulo 2^AW on their own.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage carries no reset; level=0 after reset makes old contents unreachable.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign pop_dat = mem[rd_ptr];
    assign full    = (level == DEPTH);
    assign empty   = (level == '0);

endmodule

// File: rtl/snd_fifo_writer.sv
// Purpose : producer side of the L/R sound FIFO pair; buffers sample pairs and writes both FIFOs in lockstep.
// Latency : pair accepted at edge N can be written (FIFO_WE=1) in cycle N+1.
// Backpr. : SND_READY drops when buffer full (or stays high and drops/counts with DROP_ON_FULL=1);
//           FIFO writes stall while either FIFO_FULL_L or FIFO_FULL_R is high.
//   Ports: CLK, RST (sync, active-high), EN, FLUSH; SND_VALID/SND_READY, L_SND_IN, R_SND_IN;
//   FIFO_FULL_L/R in, FIFO_WE, FIFO_DIN_L/R out; FLUSH_DONE pulse, LEVEL, OVF_CNT.
import snd_pkg::*;

module snd_fifo_writer #(
    parameter int          AW           = 2,
    parameter bit          DROP_ON_FULL = 1'b0,
    parameter logic [15:0] PAD          = 16'h0000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              FLUSH,
    input  logic              SND_VALID,
    output logic              SND_READY,
    input  logic [SND_W-1:0]  L_SND_IN,
    input  logic [SND_W-1:0]  R_SND_IN,
    input  logic              FIFO_FULL_L,
    input  logic              FIFO_FULL_R,
    output logic              FIFO_WE,
    output logic [FIFO_W-1:0] FIFO_DIN_L,
    output logic [FIFO_W-1:0] FIFO_DIN_R,
    output logic              FLUSH_DONE,
    output logic [AW:0]       LEVEL,
    output logic [15:0]       OVF_CNT
);

    snd_state_t        state;
    logic              buf_full;
    logic              buf_empty;
    logic [FIFO_W-1:0] head_dat;
    logic              hs;
    logic              push;
    logic              pop;
    logic              drop;

    // Ready looks only at registered level: a same-cycle pop never frees a slot.
    assign SND_READY = (state == ST_RUN) & (~buf_full | DROP_ON_FULL);
    assign hs        = SND_VALID & SND_READY;
    assign push      = hs & ~buf_full;
    assign drop      = hs & buf_full;

    // One strobe for both FIFOs, gated by both FULLs, so L and R cannot skew.
    assign pop = ((state == ST_RUN) | (state == ST_DRAIN)) & ~buf_empty
                 & ~FIFO_FULL_L & ~FIFO_FULL_R;

    snd_pair_buf #(.AW(AW)) u_buf (
        .CLK      (CLK),
        .RST      (RST),
        .push     (push),
        .push_dat ({L_SND_IN, R_SND_IN}),
        .pop      (pop),
        .pop_dat  (head_dat),
        .level    (LEVEL),
        .full     (buf_full),
        .empty    (buf_empty)
    );

    assign FIFO_WE    = pop;
    assign FIFO_DIN_L = fmt_l(head_dat[FIFO_W-1:SND_W], PAD);
    assign FIFO_DIN_R = fmt_r(head_dat[SND_W-1:0], PAD);
    assign FLUSH_DONE = (state == ST_DONE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            OVF_CNT <= '0;
        end else begin
            case (state)
                ST_IDLE:  if (EN) state <= ST_RUN;
                // FLUSH outranks EN; buffered pairs survive a drop back to IDLE.
                ST_RUN: begin
                    if (FLUSH)    state <= ST_DRAIN;
                    else if (!EN) state <= ST_IDLE;
                end
                ST_DRAIN: if (buf_empty) state <= ST_DONE;
                ST_DONE:  state <= EN ? ST_RUN : ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
            if (drop && (OVF_CNT != 16'hFFFF)) OVF_CNT <= OVF_CNT + 16'd1;
        end
    end

endmodule

// File: tb/tb_snd_fifo_writer.sv
module tb_snd_fifo_writer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        EN = 1'b0;
    logic        FLUSH = 1'b0;
    logic        SND_VALID = 1'b0;
    logic [15:0] L_SND_IN = '0;
    logic [15:0] R_SND_IN = '0;
    logic        FIFO_FULL_L = 1'b0;
    logic        FIFO_FULL_R = 1'b0;

    logic        rdy0, we0, fd0, rdy1, we1, fd1;
    logic [31:0] dl0, dr0, dl1, dr1;
    logic [2:0]  lvl0, lvl1;
    logic [15:0] ovf0, ovf1;

    int nvec = 0;
    int nmis = 0;

    always #5 CLK = ~CLK;

    snd_fifo_writer #(.AW(2), .DROP_ON_FULL(1'b0), .PAD(16'h0000)) dut0 (
        .CLK(CLK), .RST(RST), .EN(EN), .FLUSH(FLUSH),
        .SND_VALID(SND_VALID), .SND_READY(rdy0),
        .L_SND_IN(L_SND_IN), .R_SND_IN(R_SND_IN),
        .FIFO_FULL_L(FIFO_FULL_L), .FIFO_FULL_R(FIFO_FULL_R),
        .FIFO_WE(we0), .FIFO_DIN_L(dl0), .FIFO_DIN_R(dr0),
        .FLUSH_DONE(fd0), .LEVEL(lvl0), .OVF_CNT(ovf0)
    );

    snd_fifo_writer #(.AW(2), .DROP_ON_FULL(1'b1), .PAD(16'h0000)) dut1 (
        .CLK(CLK), .RST(RST), .EN(EN), .FLUSH(FLUSH),
        .SND_VALID(SND_VALID), .SND_READY(rdy1),
        .L_SND_IN(L_SND_IN), .R_SND_IN(R_SND_IN),
        .FIFO_FULL_L(FIFO_FULL_L), .FIFO_FULL_R(FIFO_FULL_R),
        .FIFO_WE(we1), .FIFO_DIN_L(dl1), .FIFO_DIN_R(dr1),
        .FLUSH_DONE(fd1), .LEVEL(lvl1), .OVF_CNT(ovf1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected FIFO words with PAD=0: byte-swapped sample in the upper (L) or lower (R) half.
    function automatic logic [31:0] exp_l(input logic [15:0] s);
        return {s[7:0], s[15:8], 16'h0000};
    endfunction

    function automatic logic [31:0] exp_r(input logic [15:0] s);
        return {16'h0000, s[7:0], s[15:8]};
    endfunction

    task automatic cyc;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RST = 1'b1; EN = 1'b0; FLUSH = 1'b0; SND_VALID = 1'b0;
        FIFO_FULL_L = 1'b0; FIFO_FULL_R = 1'b0;
        cyc;
        cyc;
        RST = 1'b0;
    endtask

    task automatic start_run;
        EN = 1'b1;
        cyc;
    endtask

    initial begin
        // 1: reset state, then single pair with format check
        do_reset;
        #1;
        chk("rst_lvl",  32'(lvl0), 32'd0);
        chk("rst_ovf",  32'(ovf0), 32'd0);
        chk("rst_rdy",  32'(rdy0), 32'd0);
        chk("rst_we",   32'(we0),  32'd0);
        chk("rst_fd",   32'(fd0),  32'd0);
        chk("rst_rdy1", 32'(rdy1), 32'd0);
        start_run;
        L_SND_IN = 16'h0123; R_SND_IN = 16'h4567; SND_VALID = 1'b1;
        #1;
        chk("t1_rdy", 32'(rdy0), 32'd1);
        cyc;
        SND_VALID = 1'b0;
        #1;
        chk("t1_we",  32'(we0), 32'd1);
        chk("t1_dl",  dl0, 32'h2301_0000);
        chk("t1_dr",  dr0, 32'h0000_6745);
        chk("t1_lvl", 32'(lvl0), 32'd1);
        cyc;
        #1;
        chk("t1_we_after",  32'(we0),  32'd0);
        chk("t1_lvl_after", 32'(lvl0), 32'd0);

        // 2: back-pressure with right FIFO full
        FIFO_FULL_R = 1'b1;
        for (int i = 0; i < 5; i++) begin
            L_SND_IN = 16'h1000 + 16'(i); R_SND_IN = 16'h2000 + 16'(i); SND_VALID = 1'b1;
            #1;
            chk("t2_rdy", 32'(rdy0), (i < 4) ? 32'd1 : 32'd0);
            cyc;
        end
        SND_VALID = 1'b0;
        #1;
        chk("t2_lvl_full", 32'(lvl0), 32'd4);
        chk("t2_we_held",  32'(we0),  32'd0);
        FIFO_FULL_R = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("t2_we", 32'(we0), 32'd1);
            chk("t2_dl", dl0, exp_l(16'h1000 + 16'(k)));
            chk("t2_dr", dr0, exp_r(16'h2000 + 16'(k)));
            cyc;
            #1;
        end
        chk("t2_lvl_end", 32'(lvl0), 32'd0);
        chk("t2_we_end",  32'(we0),  32'd0);

        // 3: drop-on-full keeps ready high and counts overflow
        do_reset;
        start_run;
        FIFO_FULL_L = 1'b1;
        for (int i = 0; i < 10; i++) begin
            L_SND_IN = 16'hA100 + 16'(i); R_SND_IN = 16'hB200 + 16'(i); SND_VALID = 1'b1;
            #1;
            chk("t3_rdy", 32'(rdy1), 32'd1);
            cyc;
        end
        SND_VALID = 1'b0;
        #1;
        chk("t3_lvl", 32'(lvl1), 32'd4);
        chk("t3_ovf", 32'(ovf1), 32'd6);
        chk("t3_we",  32'(we1),  32'd0);
        FIFO_FULL_L = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("t3_we_rel", 32'(we1), 32'd1);
            chk("t3_dl", dl1, exp_l(16'hA100 + 16'(k)));
            chk("t3_dr", dr1, exp_r(16'hB200 + 16'(k)));
            cyc;
            #1;
        end
        chk("t3_lvl_end", 32'(lvl1), 32'd0);

        // 4: flush drains 3 pairs, one-cycle FLUSH_DONE, back to RUN
        do_reset;
        start_run;
        FIFO_FULL_L = 1'b1;
        for (int i = 0; i < 3; i++) begin
            L_SND_IN = 16'hC000 + 16'(i); R_SND_IN = 16'hD000 + 16'(i); SND_VALID = 1'b1;
            cyc;
        end
        SND_VALID = 1'b0;
        #1;
        chk("t4_lvl", 32'(lvl0), 32'd3);
        FLUSH = 1'b1;
        cyc;
        FLUSH = 1'b0;
        #1;
        chk("t4_rdy_drain", 32'(rdy0), 32'd0);
        chk("t4_we_full",   32'(we0),  32'd0);
        chk("t4_fd_early",  32'(fd0),  32'd0);
        FIFO_FULL_L = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("t4_we", 32'(we0), 32'd1);
            chk("t4_dl", dl0, exp_l(16'hC000 + 16'(k)));
            chk("t4_dr", dr0, exp_r(16'hD000 + 16'(k)));
            cyc;
            #1;
        end
        chk("t4_we_empty", 32'(we0),  32'd0);
        chk("t4_lvl_end",  32'(lvl0), 32'd0);
        chk("t4_fd_pre",   32'(fd0),  32'd0);
        cyc;
        #1;
        chk("t4_fd",      32'(fd0),  32'd1);
        chk("t4_rdy_done", 32'(rdy0), 32'd0);
        cyc;
        #1;
        chk("t4_fd_gone", 32'(fd0),  32'd0);
        chk("t4_rdy_run", 32'(rdy0), 32'd1);

        // 5: reset during drain discards buffer, no FLUSH_DONE
        do_reset;
        start_run;
        FIFO_FULL_L = 1'b1;
        for (int i = 0; i < 2; i++) begin
            L_SND_IN = 16'h5500 + 16'(i); R_SND_IN = 16'h6600 + 16'(i); SND_VALID = 1'b1;
            cyc;
        end
        SND_VALID = 1'b0;
        FLUSH = 1'b1;
        cyc;
        FLUSH = 1'b0;
        #1;
        chk("t5_lvl_drain", 32'(lvl0), 32'd2);
        RST = 1'b1;
        FIFO_FULL_L = 1'b0;
        cyc;
        RST = 1'b0;
        #1;
        chk("t5_lvl", 32'(lvl0), 32'd0);
        chk("t5_we",  32'(we0),  32'd0);
        chk("t5_rdy", 32'(rdy0), 32'd0);
        chk("t5_fd",  32'(fd0),  32'd0);
        cyc;
        #1;
        chk("t5_fd_next",  32'(fd0),  32'd0);
        chk("t5_rdy_next", 32'(rdy0), 32'd1);

        // 6: streaming, push and pop every cycle
        do_reset;
        start_run;
        for (int i = 0; i < 8; i++) begin
            L_SND_IN = 16'hE000 + 16'(i); R_SND_IN = 16'hF000 + 16'(i); SND_VALID = 1'b1;
            #1;
            chk("t6_rdy", 32'(rdy0), 32'd1);
            if (i == 0) begin
                chk("t6_lvl0", 32'(lvl0), 32'd0);
            end else begin
                chk("t6_lvl", 32'(lvl0), 32'd1);
                chk("t6_we",  32'(we0),  32'd1);
                chk("t6_dl",  dl0, exp_l(16'hE000 + 16'(i - 1)));
                chk("t6_dr",  dr0, exp_r(16'hF000 + 16'(i - 1)));
            end
            cyc;
        end
        SND_VALID = 1'b0;
        #1;
        chk("t6_we_last", 32'(we0), 32'd1);
        chk("t6_dl_last", dl0, exp_l(16'hE007));
        cyc;
        #1;
        chk("t6_lvl_end", 32'(lvl0), 32'd0);
        chk("t6_we_end",  32'(we0),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
